jk_bank_scheduler: RTL and testbench

//  Shares one bank of WIDTH JK flip-flop bits between two requesters.

---
 rtl/jk_bank_scheduler_if.sv | 26 ++
 rtl/jk_bank_scheduler.sv | 165 ++++++++++++++++
 tb/tb_jk_bank_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jk_bank_scheduler_if.sv
// Command handshake between two requesters and the shared JK bank scheduler.
// The master side issues {J,K} commands; the slave side returns ack/rdata/err.
interface jk_bank_scheduler_if #(
   parameter int IDX_W = 3
);
   logic             req0;
   logic [1:0]       op0;
   logic [IDX_W-1:0] idx0;
   logic             ack0;
   logic             req1;
   logic [1:0]       op1;
   logic [IDX_W-1:0] idx1;
   logic             ack1;
   logic             rdata;
   logic             err;

   modport master (
      output req0, op0, idx0, req1, op1, idx1,
      input  ack0, ack1, rdata, err
   );

   modport slave (
      input  req0, op0, idx0, req1, op1, idx1,
      output ack0, ack1, rdata, err
   );
endinterface

// File: rtl/jk_bank_scheduler.sv
// Bank of JK bits shared by two requesters; a round-robin arbiter and an
// IDLE/EXEC/ACK sequencer apply one {J,K} command at a time.
module jk_bank_scheduler #(
   parameter int               WIDTH = 6,
   parameter int               IDX_W = 3,
   parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
   input  logic               clk,
   input  logic               reset_n,
   jk_bank_scheduler_if.slave bus,
   output logic               busy,
   output logic [WIDTH-1:0]   q,
   output logic [WIDTH-1:0]   qbar
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   state_t           state_r;
   state_t           next_state_s;

   logic             any_req_s;
   logic             grant1_s;
   logic             latch_s;
   logic             id_r;
   logic             ptr_r;
   logic [1:0]       op_r;
   logic [IDX_W-1:0] idx_r;

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_s;
   logic [WIDTH-1:0] match_s;
   logic             hit_s;
   logic             cur_bit_s;
   logic             new_bit_s;

   logic             ack0_s;
   logic             ack1_s;
   logic             rdata_s;
   logic             err_s;
   logic             busy_s;
   logic             ack0_r;
   logic             ack1_r;
   logic             rdata_r;
   logic             err_r;
   logic             busy_r;

   // Each bit behaves as a T flip-flop driven by T = J&~Q | K&Q.
   function automatic logic jk_next(input logic j, input logic k, input logic cur);
      logic t;
      t = (j & ~cur) | (k & cur);
      return cur ^ t;
   endfunction

   // ptr_r == 0 favours requester 0 when both ask at once
   assign any_req_s = bus.req0 | bus.req1;
   assign grant1_s  = bus.req1 & (~bus.req0 | ptr_r);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (any_req_s) begin
               next_state_s = ST_EXEC;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_EXEC: next_state_s = ST_ACK;
         ST_ACK:  next_state_s = ST_IDLE;
         default: next_state_s = ST_IDLE;
      endcase
   end

   // One-hot select of the latched index; all-zero when the index is out of range
   always_comb begin
      match_s = {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         match_s[i] = (idx_r == i[IDX_W-1:0]);
      end
   end

   assign hit_s     = |match_s;
   assign cur_bit_s = |(match_s & q_r);
   assign new_bit_s = jk_next(op_r[1], op_r[0], cur_bit_s);

   // Output logic: next values of the bank and of the registered outputs
   always_comb begin
      q_s     = q_r;
      ack0_s  = 1'b0;
      ack1_s  = 1'b0;
      rdata_s = 1'b0;
      err_s   = 1'b0;
      latch_s = 1'b0;
      case (state_r)
         ST_IDLE: latch_s = any_req_s;
         ST_EXEC: begin
            q_s     = (q_r & ~match_s) | ({WIDTH{new_bit_s}} & match_s);
            rdata_s = hit_s & new_bit_s;
            err_s   = ~hit_s;
            ack0_s  = ~id_r;
            ack1_s  = id_r;
         end
         ST_ACK:  latch_s = 1'b0;
         default: latch_s = 1'b0;
      endcase
      busy_s = (next_state_s != ST_IDLE);
   end

   // Command latch and round-robin pointer, updated only on a grant
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         id_r  <= 1'b0;
         ptr_r <= 1'b0;
         op_r  <= 2'b00;
         idx_r <= {IDX_W{1'b0}};
      end else if (latch_s) begin
         id_r  <= grant1_s;
         ptr_r <= ~grant1_s;
         op_r  <= grant1_s ? bus.op1 : bus.op0;
         idx_r <= grant1_s ? bus.idx1 : bus.idx0;
      end
   end

   // Bank and registered handshake outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_r     <= INIT;
         ack0_r  <= 1'b0;
         ack1_r  <= 1'b0;
         rdata_r <= 1'b0;
         err_r   <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         q_r     <= q_s;
         ack0_r  <= ack0_s;
         ack1_r  <= ack1_s;
         rdata_r <= rdata_s;
         err_r   <= err_s;
         busy_r  <= busy_s;
      end
   end

   assign bus.ack0  = ack0_r;
   assign bus.ack1  = ack1_r;
   assign bus.rdata = rdata_r;
   assign bus.err   = err_r;
   assign busy      = busy_r;
   assign q         = q_r;
   assign qbar      = ~q_r;

endmodule

// File: tb/tb_jk_bank_scheduler.sv
// Self-checking bench for jk_bank_scheduler: directed vector table, hand
// sequences for reset/contention/back-to-back/stability, and a random phase.
module tb_jk_bank_scheduler;
   localparam int WIDTH = 6;
   localparam int IDX_W = 3;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             busy;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qbar;
   logic [WIDTH-1:0] qinv;

   int n_tests = 0;
   int n_fail  = 0;

   jk_bank_scheduler_if #(.IDX_W(IDX_W)) bus();

   jk_bank_scheduler #(
      .WIDTH(WIDTH),
      .IDX_W(IDX_W),
      .INIT (6'b000000)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus),
      .busy   (busy),
      .q      (q),
      .qbar   (qbar)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             r;
      logic [1:0]       op;
      logic [IDX_W-1:0] idx;
      logic [WIDTH-1:0] eq;
      logic             erd;
      logic             eerr;
   } vec_t;

   vec_t tbl [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // invariants checked every cycle outside reset
   always @(negedge clk) begin
      if (reset_n) begin
         qinv = ~q;
         check("qbar_inv", qbar, qinv);
         check("ack_excl", bus.ack0 & bus.ack1, 1'b0);
      end
   end

   task automatic idle_inputs();
      bus.req0 = 1'b0; bus.op0 = 2'b00; bus.idx0 = 3'd0;
      bus.req1 = 1'b0; bus.op1 = 2'b00; bus.idx1 = 3'd0;
   endtask

   // issue one command from an idle DUT; returns at the negedge where ack shows
   task automatic run_cmd(input logic r, input logic [1:0] op, input logic [IDX_W-1:0] idx,
                          output int lat);
      if (r) begin
         bus.req1 = 1'b1; bus.op1 = op; bus.idx1 = idx;
      end else begin
         bus.req0 = 1'b1; bus.op0 = op; bus.idx0 = idx;
      end
      lat = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (r ? bus.ack1 : bus.ack0) begin
            lat = i;
            break;
         end
      end
      if (r) bus.req1 = 1'b0;
      else   bus.req0 = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic drive_random();
      if (!bus.req0) begin
         if ($urandom_range(0, 2) == 0) begin
            bus.req0 = 1'b1; bus.op0 = 2'($urandom_range(0, 3)); bus.idx0 = 3'($urandom_range(0, 7));
         end
      end else if (bus.ack0) begin
         if ($urandom_range(0, 1) == 1) begin
            bus.op0 = 2'($urandom_range(0, 3)); bus.idx0 = 3'($urandom_range(0, 7));
         end else begin
            bus.req0 = 1'b0;
         end
      end
      if (!bus.req1) begin
         if ($urandom_range(0, 2) == 0) begin
            bus.req1 = 1'b1; bus.op1 = 2'($urandom_range(0, 3)); bus.idx1 = 3'($urandom_range(0, 7));
         end
      end else if (bus.ack1) begin
         if ($urandom_range(0, 1) == 1) begin
            bus.op1 = 2'($urandom_range(0, 3)); bus.idx1 = 3'($urandom_range(0, 7));
         end else begin
            bus.req1 = 1'b0;
         end
      end
   endtask

   // Transaction-level model: a grant at edge g commits at g+1, acks after g+1,
   // and the scheduler is free again to grant at edge g+3.
   task automatic random_phase(input int ncyc);
      int               g;
      logic             win, mptr, e_rd, e_err, nb;
      logic [1:0]       mop;
      logic [IDX_W-1:0] midx;
      logic [WIDTH-1:0] mq, vq;
      g = -10; mptr = 1'b0; mq = '0; vq = '0; win = 1'b0; e_rd = 1'b0; e_err = 1'b0;
      for (int e = 0; e < ncyc; e++) begin
         drive_random();
         if (e >= g + 3 && (bus.req0 || bus.req1)) begin
            win  = (bus.req0 && bus.req1) ? mptr : bus.req1;
            mop  = win ? bus.op1 : bus.op0;
            midx = win ? bus.idx1 : bus.idx0;
            if (int'(midx) < WIDTH) begin
               case (mop)
                  2'b00:   nb = mq[midx];
                  2'b01:   nb = 1'b0;
                  2'b10:   nb = 1'b1;
                  default: nb = ~mq[midx];
               endcase
               mq[midx] = nb;
               e_rd = nb; e_err = 1'b0;
            end else begin
               e_rd = 1'b0; e_err = 1'b1;
            end
            mptr = ~win;
            g = e;
         end
         @(negedge clk);
         if (e == g + 1) vq = mq;
         check("rnd_busy",  busy,      (e == g || e == g + 1));
         check("rnd_ack0",  bus.ack0,  (e == g + 1) && !win);
         check("rnd_ack1",  bus.ack1,  (e == g + 1) && win);
         check("rnd_rdata", bus.rdata, (e == g + 1) ? e_rd : 1'b0);
         check("rnd_err",   bus.err,   (e == g + 1) ? e_err : 1'b0);
         check("rnd_q",     q,         vq);
      end
      idle_inputs();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      int lat, cnt;
      int ack_cyc [4];
      int ack_id  [4];
      logic exp5;

      tbl[0]  = '{1'b0, 2'b10, 3'd2, 6'b000100, 1'b1, 1'b0};
      tbl[1]  = '{1'b0, 2'b11, 3'd2, 6'b000000, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 2'b00, 3'd2, 6'b000000, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 2'b10, 3'd2, 6'b000100, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 2'b01, 3'd2, 6'b000000, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 2'b10, 3'd7, 6'b000000, 1'b0, 1'b1};
      tbl[6]  = '{1'b1, 2'b10, 3'd6, 6'b000000, 1'b0, 1'b1};
      tbl[7]  = '{1'b1, 2'b10, 3'd5, 6'b100000, 1'b1, 1'b0};
      tbl[8]  = '{1'b1, 2'b00, 3'd5, 6'b100000, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 2'b11, 3'd0, 6'b100001, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 2'b01, 3'd5, 6'b000001, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 2'b01, 3'd3, 6'b000001, 1'b0, 1'b0};
      tbl[12] = '{1'b1, 2'b11, 3'd0, 6'b000000, 1'b0, 1'b0};

      idle_inputs();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_q", q, 6'b000000);
      check("rst_busy", busy, 1'b0);
      check("rst_ack0", bus.ack0, 1'b0);
      check("rst_ack1", bus.ack1, 1'b0);
      check("rst_rdata", bus.rdata, 1'b0);
      check("rst_err", bus.err, 1'b0);
      reset_n = 1'b1;
      @(negedge clk);
      check("idle_busy", busy, 1'b0);
      check("idle_q", q, 6'b000000);

      // directed vector table
      for (int i = 0; i < 13; i++) begin
         run_cmd(tbl[i].r, tbl[i].op, tbl[i].idx, lat);
         check($sformatf("vec%0d_latency", i), lat, 2);
         check($sformatf("vec%0d_rdata", i), bus.rdata, tbl[i].erd);
         check($sformatf("vec%0d_err", i), bus.err, tbl[i].eerr);
         check($sformatf("vec%0d_q", i), q, tbl[i].eq);
         check($sformatf("vec%0d_other_ack", i), tbl[i].r ? bus.ack0 : bus.ack1, 1'b0);
         @(negedge clk);
         check($sformatf("vec%0d_ack_drop", i), bus.ack0 | bus.ack1, 1'b0);
         check($sformatf("vec%0d_busy_drop", i), busy, 1'b0);
      end

      // reset while a command is executing
      run_cmd(1'b0, 2'b10, 3'd3, lat);
      check("pre_rst_q", q, 6'b001000);
      @(negedge clk);
      bus.req0 = 1'b1; bus.op0 = 2'b10; bus.idx0 = 3'd1;
      @(negedge clk);
      check("midexec_busy", busy, 1'b1);
      reset_n = 1'b0;
      #1;
      check("midrst_q", q, 6'b000000);
      check("midrst_busy", busy, 1'b0);
      check("midrst_ack0", bus.ack0, 1'b0);
      bus.req0 = 1'b0;
      @(negedge clk);
      check("midrst_q_hold", q, 6'b000000);
      check("midrst_noack", bus.ack0, 1'b0);

      // contention straight out of reset: both held for four commands
      bus.req0 = 1'b1; bus.op0 = 2'b10; bus.idx0 = 3'd0;
      bus.req1 = 1'b1; bus.op1 = 2'b10; bus.idx1 = 3'd1;
      reset_n = 1'b1;
      cnt = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (bus.ack0 || bus.ack1) begin
            if (cnt < 4) begin
               ack_cyc[cnt] = c;
               ack_id[cnt]  = bus.ack1 ? 1 : 0;
            end
            cnt++;
         end
      end
      idle_inputs();
      check("cont_count", cnt, 4);
      for (int k = 0; k < 4 && k < cnt; k++) begin
         check($sformatf("cont_id%0d", k), ack_id[k], k % 2);
         check($sformatf("cont_cyc%0d", k), ack_cyc[k], 2 + 3 * k);
      end
      check("cont_q", q, 6'b000011);
      @(negedge clk);

      // back-to-back toggles on idx 5 from requester 0
      bus.req0 = 1'b1; bus.op0 = 2'b11; bus.idx0 = 3'd5;
      cnt = 0;
      exp5 = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (bus.ack0) begin
            exp5 = ~exp5;
            check($sformatf("b2b_cyc%0d", cnt), c, 2 + 3 * cnt);
            check($sformatf("b2b_q5_%0d", cnt), q[5], exp5);
            check($sformatf("b2b_rdata%0d", cnt), bus.rdata, exp5);
            cnt++;
         end
      end
      idle_inputs();
      check("b2b_count", cnt, 4);
      check("b2b_q", q, 6'b000011);
      @(negedge clk);

      // op/idx changed after the grant must be ignored
      bus.req0 = 1'b1; bus.op0 = 2'b10; bus.idx0 = 3'd4;
      @(negedge clk);
      bus.op0 = 2'b01; bus.idx0 = 3'd1;
      lat = 0;
      for (int i = 2; i <= 8; i++) begin
         @(negedge clk);
         if (bus.ack0) begin
            lat = i;
            break;
         end
      end
      bus.req0 = 1'b0;
      check("stab_latency", lat, 2);
      check("stab_rdata", bus.rdata, 1'b1);
      check("stab_err", bus.err, 1'b0);
      check("stab_q", q, 6'b010011);
      @(negedge clk);

      // randomized traffic against the transaction model
      do_reset();
      random_phase(1500);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
